shift_sequencer: RTL
====================

// Module: shift_sequencer
//
// PURPOSE
//   Multi-cycle controller for the 16-bit single-position shifter
//   (shift codes: 00 pass, 01 LSL by 1, 10 LSR by 1, 11 ASR by 1).
//   It shifts an operand by 0..15 positions by iterating the external shifter
//   once per cycle. A working register feeds the shifter and captures its
//   output on each step.
//   It sits beside the datapath and fronts a start/done handshake to the FSM.
//
// PARAMETERS
//   WIDTH   16  operand width; must equal the shifter width
//   CNT_W    4  shift-amount width; max amount = 2**CNT_W-1
//
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   start     in   1      request; sampled only in IDLE
//   op        in   2      shift code applied on every step (00/01/10/11)
//   amount    in   CNT_W  number of single-position steps
//   din       in   WIDTH  operand
//   sh_in     out  WIDTH  to shifter .in  (= working register)
//   sh_shift  out  2      to shifter .shift
//   sh_sout   in   WIDTH  from shifter .sout
//   dout      out  WIDTH  result (= working register)
//   busy      out  1      1 while in SHIFT
//   done      out  1      one-cycle pulse: result valid
//
// BEHAVIOUR
//   - Reset (async, any state, mid-operation included) gives:
//     state=IDLE, work=0, cnt=0, busy=0, done=0, dout=0, sh_shift=00.
//     An aborted operation never produces done.
//   - States:
//     IDLE: start=1 -> SHIFT; load work<=din, cnt<=amount, opr<=op.
//     SHIFT: cnt!=0 -> work<=sh_sout, cnt<=cnt-1, stay in SHIFT.
//     SHIFT: cnt==0 -> DONE.
//     DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//   - sh_shift = opr when (state==SHIFT && cnt!=0), else 00.
//     sh_in = work at all times.
//   - Latency: start sampled at edge E0 -> done high after edge E0+amount+1.
//     This holds for every op, including 00 and amount 0 (done after E0+1).
//   - start is ignored in SHIFT and DONE; no queuing.
//     op, amount and din are don't-care after E0 (latched).
//   - dout holds the last result through IDLE until the next start reloads work.
//   - Shift semantics are the shifter's:
//     LSL fills 0 at bit 0; LSR fills 0 at MSB; ASR replicates MSB.
//     Bits shifted out are lost. No wrap; amount never exceeds 2**CNT_W-1.
//
// CONFIGURATION
//   SHIFT_SEQ_STATUS_EN defined:
//     Adds two outputs:
//       zf  out  1  (dout==0)
//       cf  out  1  last bit shifted out
//     cf rules:
//       - On each step with cnt!=0, cf <= work[WIDTH-1] for op 01,
//         and cf <= work[0] for op 10/11; op 00 leaves cf unchanged.
//       - cf clears to 0 on load in IDLE and on reset.
//       - zf and cf are valid with done and held until the next start.
//   SHIFT_SEQ_STATUS_EN undefined: zf/cf ports and their logic are absent.
//     Core timing is identical in both builds.
//
// TESTING
//   1. Reset mid-run: start op=01 amt=8, assert reset after 3 cycles ->
//      busy=0, done never pulses, dout=0.
//   2. din=16'h82C5 op=01 amt=1 -> done after E0+2; dout=16'h058A.
//   3. din=16'h82C5 op=11 amt=1 -> dout=16'hC162; op=10 amt=1 -> 16'h4162.
//   4. Extremes:
//      din=16'h8000 op=11 amt=15 -> dout=16'hFFFF, done after E0+16.
//      din=16'h0001 op=01 amt=15 -> dout=16'h8000.
//   5. amt=0 and op=00 amt=5:
//      din=16'h1234 amt=0 -> dout=16'h1234, done after E0+1.
//      op=00 amt=5 -> dout=16'h1234, done after E0+6.
//      Second start while busy is ignored (single done, no re-load).
//   6. STATUS_EN build:
//      din=16'h0001 op=10 amt=1 -> dout=0, zf=1, cf=1.
//      din=16'h4000 op=01 amt=2 -> dout=0, zf=1, cf=1.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer that shifts an operand by 0..2**CNT_W-1 positions by stepping an
// external single-position shifter once per cycle. Optional zf/cf status flags: SHIFT_SEQ_STATUS_EN.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sh_in,
    output logic [1:0]       sh_shift,
    input  logic [WIDTH-1:0] sh_sout,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
`ifdef SHIFT_SEQ_STATUS_EN
    ,
    output logic             zf,
    output logic             cf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         opr_q, opr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SHIFT_SEQ_STATUS_EN
    logic               cf_q, cf_d;
`endif

    logic step;
    assign step = (state_q == SHIFT) && (cnt_q != '0);

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
`ifdef SHIFT_SEQ_STATUS_EN
        cf_d    = cf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    work_d  = din;
                    cnt_d   = amount;
                    opr_d   = op;
`ifdef SHIFT_SEQ_STATUS_EN
                    cf_d    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = sh_sout;
                    cnt_d  = cnt_q - CNT_W'(1);
`ifdef SHIFT_SEQ_STATUS_EN
                    // cf tracks the bit that leaves the word on this step; pass keeps it.
                    if (opr_q == 2'b01)
                        cf_d = work_q[WIDTH-1];
                    else if (opr_q != 2'b00)
                        cf_d = work_q[0];
`endif
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            opr_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_SEQ_STATUS_EN
            cf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_SEQ_STATUS_EN
            cf_q    <= cf_d;
`endif
        end
    end

    assign sh_in    = work_q;
    assign sh_shift = step ? opr_q : 2'b00;
    assign dout     = work_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef SHIFT_SEQ_STATUS_EN
    assign zf       = (work_q == '0);
    assign cf       = cf_q;
`endif

endmodule
